video_bus_master_writer: RTL and testbench

//  Initiator side of the Computer_System video external bus-master port. Accepts pixel read/write

---
 rtl/video_bus_master_writer_pkg.sv | 29 ++
 rtl/video_bus_master_writer_fifo.sv | 55 +++++
 rtl/video_bus_master_writer.sv | 161 ++++++++++++++++
 tb/tb_video_bus_master_writer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_bus_master_writer_pkg.sv
// Shared types for the video bus-master writer: FSM states, queued pixel request
// and the (x,y) -> bus address mapping.
package video_bus_pkg;

  localparam int STRIDE_BITS = 10;
  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } bus_state_t;

  typedef struct packed {
    logic           write;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [7:0]     data;
  } pixel_req_t;

  // Rows are spaced 1024 bytes apart; the sum wraps at 30 bits.
  function automatic logic [29:0] pixel_addr(input logic [29:0]    base,
                                             input logic [X_W-1:0] x,
                                             input logic [Y_W-1:0] y);
    return base + (30'(y) << STRIDE_BITS) + 30'(x);
  endfunction

endpackage

// File: rtl/video_bus_master_writer_fifo.sv
// Show-ahead request FIFO: the head entry is visible combinationally while not empty.
module pixel_req_fifo
  import video_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  pixel_req_t i_push_data,
  input  logic       i_pop,
  output pixel_req_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  pixel_req_t     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == FULL_COUNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/video_bus_master_writer.sv
// Turns queued (x,y) pixel requests into single-byte bus transactions with
// strobes held until acknowledge, a bounded wait and a mandatory idle gap.
module video_bus_master_writer
  import video_bus_pkg::*;
#(
  parameter logic [29:0] BASE_ADDR  = 30'h0800_0000,
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          FIFO_DEPTH = 4,
  parameter int          TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [9:0]  req_x,
  input  logic [8:0]  req_y,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        err_oob,
  output logic        err_timeout,
  output logic [29:0] bus_address,
  output logic        bus_byte_enable,
  output logic        bus_read,
  output logic        bus_write,
  output logic [7:0]  bus_write_data,
  input  logic        bus_acknowledge,
  input  logic [7:0]  bus_read_data
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0] H_LIM = 32'(H_RES);
  localparam logic [31:0] V_LIM = 32'(V_RES);

  pixel_req_t        w_push_req;
  pixel_req_t        w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_in_range;

  bus_state_t        r_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_run;
  logic [29:0]       r_addr;
  logic [7:0]        r_wdata;
  logic              r_bus_read;
  logic              r_bus_write;
  logic              r_byte_en;
  logic              r_rsp_valid;
  logic [7:0]        r_rsp_data;
  logic              r_err_oob;
  logic              r_err_timeout;

  assign w_push_req = '{write: req_write, x: req_x, y: req_y, data: req_data};
  // r_run keeps req_ready low while reset is held and for the release edge.
  assign req_ready  = r_run && !w_full;
  assign w_push     = req_valid && req_ready;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_in_range = ({22'd0, w_head.x} < H_LIM) && ({23'd0, w_head.y} < V_LIM);

  pixel_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_data(w_push_req),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_run         <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_bus_read    <= 1'b0;
      r_bus_write   <= 1'b0;
      r_byte_en     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_err_oob     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_err_oob     <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            if (w_in_range) begin
              r_addr      <= pixel_addr(BASE_ADDR, w_head.x, w_head.y);
              r_wdata     <= w_head.write ? w_head.data : 8'h00;
              r_bus_write <= w_head.write;
              r_bus_read  <= !w_head.write;
              r_byte_en   <= 1'b1;
              r_wait_cnt  <= '0;
              r_state     <= S_ISSUE;
            end else begin
              r_err_oob <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // Acknowledge is checked first so an ack in the final wait cycle still completes.
          if (bus_acknowledge) begin
            if (r_bus_read) begin
              r_rsp_data  <= bus_read_data;
              r_rsp_valid <= 1'b1;
            end
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
            r_byte_en   <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_state     <= S_GAP;
          end else if (r_wait_cnt == LAST_WAIT) begin
            r_err_timeout <= 1'b1;
            r_bus_read    <= 1'b0;
            r_bus_write   <= 1'b0;
            r_byte_en     <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_state       <= S_GAP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy            = !w_empty || (r_state != S_IDLE);
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign err_oob         = r_err_oob;
  assign err_timeout     = r_err_timeout;
  assign bus_address     = r_addr;
  assign bus_byte_enable = r_byte_en;
  assign bus_read        = r_bus_read;
  assign bus_write       = r_bus_write;
  assign bus_write_data  = r_wdata;

endmodule

// File: tb/tb_video_bus_master_writer.sv
// Directed bench for video_bus_master_writer: expected bus/response/error events are
// queued as requests are issued and a negedge monitor pops and compares them.
module tb_video_bus_master_writer;

  localparam logic [2:0] EV_WR  = 3'd0;
  localparam logic [2:0] EV_RD  = 3'd1;
  localparam logic [2:0] EV_RSP = 3'd2;
  localparam logic [2:0] EV_OOB = 3'd3;
  localparam logic [2:0] EV_TO  = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [29:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [9:0]  req_x = '0;
  logic [8:0]  req_y = '0;
  logic [7:0]  req_data = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        err_oob;
  logic        err_timeout;
  logic [29:0] bus_address;
  logic        bus_byte_enable;
  logic        bus_read;
  logic        bus_write;
  logic [7:0]  bus_write_data;
  logic        bus_acknowledge = 1'b0;
  logic [7:0]  bus_read_data = '0;

  ev_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic        prev_str = 1'b0;
  int          hi_len = 0;
  int          last_len = 0;
  logic [29:0] held_addr = '0;
  logic [7:0]  held_data = '0;

  video_bus_master_writer dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_x          (req_x),
    .req_y          (req_y),
    .req_data       (req_data),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .busy           (busy),
    .err_oob        (err_oob),
    .err_timeout    (err_timeout),
    .bus_address    (bus_address),
    .bus_byte_enable(bus_byte_enable),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_write_data (bus_write_data),
    .bus_acknowledge(bus_acknowledge),
    .bus_read_data  (bus_read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] kind, input logic [29:0] a, input logic [7:0] d);
    exp_q.push_back('{kind: kind, addr: a, data: d});
  endtask

  task automatic observe(input logic [2:0] kind, input logic [29:0] a, input logic [7:0] d);
    ev_t e;
    $display("[TB] t=%0t event kind=%0d addr=%08h data=%02h", $time, kind, a, d);
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %08h, required none", kind, a);
    end else begin
      n_tests--;
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      check("event_addr", 32'(a), 32'(e.addr));
      check("event_data", 32'(d), 32'(e.data));
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_str = 1'b0;
      hi_len   = 0;
    end else begin
      if (bus_read && bus_write) check("strobes_exclusive", 32'(bus_read & bus_write), 32'd0);
      if (rsp_valid)   observe(EV_RSP, 30'd0, rsp_data);
      if (err_oob)     observe(EV_OOB, 30'd0, 8'd0);
      if (err_timeout) observe(EV_TO, 30'd0, 8'd0);
      if ((bus_read || bus_write) && !prev_str) begin
        observe(bus_write ? EV_WR : EV_RD, bus_address, bus_write ? bus_write_data : 8'd0);
        held_addr = bus_address;
        held_data = bus_write_data;
        hi_len    = 1;
      end else if (bus_read || bus_write) begin
        hi_len++;
        check("addr_stable", 32'(bus_address), 32'(held_addr));
        check("wdata_stable", 32'(bus_write_data), 32'(held_data));
      end else if (prev_str) begin
        last_len = hi_len;
      end
      prev_str = bus_read || bus_write;
    end
  end

  task automatic push(input logic w, input logic [9:0] x, input logic [8:0] y,
                      input logic [7:0] d, input logic oob, input logic [29:0] exp_addr);
    int k;
    k = 0;
    while (!req_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("push_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_x     = x;
    req_y     = y;
    req_data  = d;
    @(negedge clk);
    req_valid = 1'b0;
    if (oob) expect_ev(EV_OOB, 30'd0, 8'd0);
    else     expect_ev(w ? EV_WR : EV_RD, exp_addr, w ? d : 8'd0);
  endtask

  // Called at a negedge; acknowledges in the n-th cycle the strobe is high.
  task automatic do_ack(input int n, input logic [7:0] rd);
    int k;
    k = 0;
    while (!(bus_read || bus_write) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("strobe_seen", 32'(bus_read | bus_write), 32'd1);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      check("strobe_held", 32'(bus_read | bus_write), 32'd1);
    end
    bus_acknowledge = 1'b1;
    bus_read_data   = rd;
    @(negedge clk);
    bus_acknowledge = 1'b0;
    bus_read_data   = 8'd0;
    check("strobe_low_after_ack", 32'(bus_read | bus_write), 32'd0);
    check("byte_en_low_after_ack", 32'(bus_byte_enable), 32'd0);
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("events_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_bus_read", 32'(bus_read), 32'd0);
    check("rst_bus_write", 32'(bus_write), 32'd0);
    check("rst_byte_en", 32'(bus_byte_enable), 32'd0);
    check("rst_address", 32'(bus_address), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_err", 32'({err_oob, err_timeout}), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // 1: write with ack in third strobe cycle
    push(1'b1, 10'd5, 9'd2, 8'hE0, 1'b0, 30'h0800_0805);
    check("t1_no_strobe_yet", 32'(bus_write), 32'd0);
    @(negedge clk);
    check("t1_write_strobe", 32'(bus_write), 32'd1);
    check("t1_byte_en", 32'(bus_byte_enable), 32'd1);
    check("t1_no_read", 32'(bus_read), 32'd0);
    do_ack(3, 8'h00);
    check("t1_busy_in_gap", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_idle_after_gap", 32'(bus_write), 32'd0);
    check("t1_not_busy", 32'(busy), 32'd0);
    drain(20);
    check("t1_write_len", 32'(last_len), 32'd3);

    // 2: read at the far corner
    push(1'b0, 10'd639, 9'd479, 8'h00, 1'b0, 30'h0807_7E7F);
    expect_ev(EV_RSP, 30'd0, 8'h1C);
    do_ack(2, 8'h1C);
    repeat (3) @(negedge clk);
    check("t2_rsp_data_held", 32'(rsp_data), 32'h1C);
    drain(20);

    // 3: five back-to-back writes, no acks until the FIFO fills
    push(1'b1, 10'd0,   9'd0, 8'h11, 1'b0, 30'h0800_0000);
    push(1'b1, 10'd1,   9'd0, 8'h22, 1'b0, 30'h0800_0001);
    push(1'b1, 10'd0,   9'd1, 8'h33, 1'b0, 30'h0800_0400);
    push(1'b1, 10'd100, 9'd3, 8'h44, 1'b0, 30'h0800_0C64);
    push(1'b1, 10'd639, 9'd0, 8'h55, 1'b0, 30'h0800_027F);
    check("t3_full_not_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      do_ack(1, 8'h00);
      if (i < 4) begin
        @(negedge clk);
        check("t3_idle_cycle", 32'(bus_read | bus_write), 32'd0);
        @(negedge clk);
        check("t3_next_issue", 32'(bus_write), 32'd1);
      end
    end
    drain(20);

    // 4: out-of-range requests dropped, next valid one issues
    push(1'b1, 10'd640, 9'd0,   8'hAB, 1'b1, 30'd0);
    push(1'b1, 10'd0,   9'd480, 8'hCD, 1'b1, 30'd0);
    push(1'b1, 10'd20,  9'd20,  8'h99, 1'b0, 30'h0800_5014);
    do_ack(1, 8'h00);
    drain(20);

    // 5: timeout, then ack on the last permitted cycle
    push(1'b0, 10'd10, 9'd10, 8'h00, 1'b0, 30'h0800_280A);
    expect_ev(EV_TO, 30'd0, 8'd0);
    drain(1200);
    check("t5_timeout_len", 32'(last_len), 32'd1024);
    check("t5_strobe_dropped", 32'(bus_read | bus_write), 32'd0);
    push(1'b0, 10'd1, 9'd1, 8'h00, 1'b0, 30'h0800_0401);
    expect_ev(EV_RSP, 30'd0, 8'h5A);
    do_ack(1024, 8'h5A);
    drain(20);
    check("t5_ack_len", 32'(last_len), 32'd1024);
    check("t5_rsp_data", 32'(rsp_data), 32'h5A);

    // 6: reset while a write is on the bus
    push(1'b1, 10'd3, 9'd4, 8'hAA, 1'b0, 30'h0800_1003);
    push(1'b1, 10'd7, 9'd7, 8'h55, 1'b0, 30'h0800_1C07);
    check("t6_write_active", 32'(bus_write), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_write", 32'(bus_write), 32'd0);
    check("t6_rst_read", 32'(bus_read), 32'd0);
    check("t6_rst_byte_en", 32'(bus_byte_enable), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_pending_events", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_ready", 32'(req_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("t6_fifo_flushed", 32'(busy), 32'd0);
    check("t6_no_strobe", 32'(bus_read | bus_write), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
